// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks,
// pads and length-tags the tail, and sequences the compression core.
module sha256_msg_padder (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   input  logic         start_empty,
   output logic [511:0] block_out,
   output logic [255:0] chain_out,
   output logic         core_start,
   input  logic         core_done,
   input  logic [255:0] core_result,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   localparam logic [255:0] IV =
      256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_PAD80,
      S_ZERO,
      S_HASH,
      S_WAIT_LOW
   } state_t;

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   logic [5:0]       ptr_q, ptr_d;
   logic [63:0]      len_q, len_d;
   logic [0:63][7:0] buf_q, buf_d;
   logic [255:0]     chain_q, chain_d;
   logic [255:0]     dig_q, dig_d;
   logic             fin_q, fin_d;
   logic             dv_q, dv_d;
   logic             rdy_q, rdy_d;
   logic             acc;

   assign acc          = in_valid && rdy_q;
   assign in_ready     = rdy_q;
   assign core_start   = (state_q == S_HASH);
   assign busy         = (state_q != S_IDLE);
   assign block_out    = buf_q;
   assign chain_out    = chain_q;
   assign digest       = dig_q;
   assign digest_valid = dv_q;

   // Next-state logic: byte capture, padding, core handshake.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      buf_d   = buf_q;
      chain_d = chain_q;
      dig_d   = dig_q;
      fin_d   = fin_q;
      dv_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               buf_d[0] = in_data;
               ptr_d    = 6'd1;
               len_d    = 64'd8;
               state_d  = in_last ? S_PAD80 : S_FILL;
            end else if (start_empty) begin
               ptr_d   = 6'd0;
               len_d   = 64'd0;
               state_d = S_PAD80;
            end
         end
         S_FILL: begin
            if (acc) begin
               buf_d[ptr_q] = in_data;
               ptr_d        = ptr_q + 6'd1;
               len_d        = len_q + 64'd8;
               if (ptr_q == 6'd63) begin
                  state_d = S_HASH;
                  ret_d   = in_last ? S_PAD80 : S_FILL;
               end else if (in_last) begin
                  state_d = S_PAD80;
               end
            end
         end
         S_PAD80: begin
            buf_d[ptr_q] = 8'h80;
            ptr_d        = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
               state_d = S_HASH;
               ret_d   = S_ZERO;
            end else begin
               state_d = S_ZERO;
            end
         end
         S_ZERO: begin
            if (ptr_q == 6'd56) begin
               for (int i = 0; i < 8; i++)
                  buf_d[56+i] = len_q[63-8*i -: 8];
               fin_d   = 1'b1;
               ptr_d   = 6'd0;
               state_d = S_HASH;
            end else begin
               buf_d[ptr_q] = 8'h00;
               ptr_d        = ptr_q + 6'd1;
               if (ptr_q == 6'd63) begin
                  state_d = S_HASH;
                  ret_d   = S_ZERO;
               end
            end
         end
         S_HASH: begin
            if (core_done) begin
               chain_d = core_result;
               if (fin_q) begin
                  dig_d = core_result;
                  dv_d  = 1'b1;
               end
               state_d = S_WAIT_LOW;
            end
         end
         S_WAIT_LOW: begin
            if (!core_done) begin
               buf_d = '0;
               if (fin_q) begin
                  chain_d = IV;
                  fin_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = ret_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      rdy_d = (state_d == S_IDLE) || (state_d == S_FILL);
   end

   // State and datapath registers; reset discards any partial message.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         ptr_q   <= 6'd0;
         len_q   <= 64'd0;
         buf_q   <= '0;
         chain_q <= IV;
         dig_q   <= '0;
         fin_q   <= 1'b0;
         dv_q    <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         buf_q   <= buf_d;
         chain_q <= chain_d;
         dig_q   <= dig_d;
         fin_q   <= fin_d;
         dv_q    <= dv_d;
         rdy_q   <= rdy_d;
      end
   end

endmodule
